// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one product bit per clock, signed or unsigned operands,
// full 2*N_BITS product held on registered outputs until the next completed multiply.
module seq_multiplier #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [N_BITS-1:0] src0,
    input  logic [N_BITS-1:0] src1,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] prod_lo,
    output logic [N_BITS-1:0] prod_hi
);

    localparam int CW = $clog2(N_BITS) + 1;
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(N_BITS - 1);
    localparam logic [N_BITS-1:0]     OP_ONE   = {{(N_BITS-1){1'b0}}, 1'b1};
    localparam logic [2*N_BITS-1:0]   ACC_ONE  = {{(2*N_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [N_BITS-1:0]   mcand_r;
    logic [N_BITS-1:0]   mplier_r;
    logic [2*N_BITS-1:0] acc_r;
    logic [2*N_BITS-1:0] prod_r;
    logic                neg_r;
    logic [CW-1:0]       cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                accept_s;
    logic                last_s;
    logic [N_BITS:0]     sum_s;

    // Two's-complement magnitude; the most negative value maps onto itself as an unsigned 2^(N-1).
    function automatic logic [N_BITS-1:0] magnitude(input logic [N_BITS-1:0] v, input logic sgn);
        if (sgn && v[N_BITS-1]) begin
            return ~v + OP_ONE;
        end else begin
            return v;
        end
    endfunction

    // Next-state logic plus the partial-sum adder (carry kept in bit N_BITS).
    always_comb begin
        state_s  = state_r;
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        last_s   = (cnt_r == CNT_LAST);
        sum_s    = {1'b0, acc_r[2*N_BITS-1:N_BITS]}
                 + (mplier_r[0] ? {1'b0, mcand_r} : {(N_BITS+1){1'b0}});
        case (state_r)
            IDLE:    state_s = accept_s ? RUN : IDLE;
            RUN:     state_s = last_s ? FIX : RUN;
            FIX:     state_s = DONE;
            DONE:    state_s = accept_s ? RUN : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered status flags, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {N_BITS{1'b0}};
            mplier_r <= {N_BITS{1'b0}};
            acc_r    <= {(2*N_BITS){1'b0}};
            prod_r   <= {(2*N_BITS){1'b0}};
            neg_r    <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN) || (state_s == FIX);
            done_r <= (state_s == DONE);
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        mcand_r  <= magnitude(src0, is_signed);
                        mplier_r <= magnitude(src1, is_signed);
                        neg_r    <= is_signed & (src0[N_BITS-1] ^ src1[N_BITS-1]);
                        acc_r    <= {(2*N_BITS){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                RUN: begin
                    acc_r    <= {sum_s, acc_r[N_BITS-1:1]};
                    mplier_r <= {1'b0, mplier_r[N_BITS-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    // Negating a zero accumulator yields zero, so no -0 can appear.
                    prod_r <= neg_r ? (~acc_r + ACC_ONE) : acc_r;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign prod_lo = prod_r[N_BITS-1:0];
    assign prod_hi = prod_r[2*N_BITS-1:N_BITS];

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus randomized checks of seq_multiplier against an arithmetic reference product.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        busy;
    logic        done;
    logic [31:0] prod_lo;
    logic [31:0] prod_hi;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int edges;
    int busy_cnt;
    int done_cnt;
    logic first_busy;
    logic hold_bad;

    seq_multiplier #(.N_BITS(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .src0(src0), .src1(src1), .busy(busy), .done(done),
        .prod_lo(prod_lo), .prod_hi(prod_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end else begin
            return {32'd0, a} * {32'd0, b};
        end
    endfunction

    // Called at a negedge: present operands with start, let the accepting edge pass.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        src0 = a; src1 = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) to the cycle where done is seen.
    task automatic wait_done(input int inject_at, input logic chk_hold, input logic [31:0] hold_val);
        edges = 1; busy_cnt = 0; hold_bad = 1'b0;
        @(negedge clk);
        first_busy = busy;
        while (!done && edges < 100) begin
            if (busy) busy_cnt++;
            if (chk_hold && prod_lo !== hold_val) hold_bad = 1'b1;
            if (edges == inject_at) begin
                start = 1'b1; src0 = 32'd9; src1 = 32'd9; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        @(negedge clk);
        launch(a, b, s);
        wait_done(-1, 1'b0, 32'd0);
        chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; src0 = 32'd0; src1 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {30'd0, busy, done, prod_hi, prod_lo}, 64'd0);
        rst = 1'b0;

        // Unsigned basic with latency, busy length and single-cycle done.
        @(negedge clk);
        launch(32'd7, 32'd6, 1'b0);
        wait_done(-1, 1'b0, 32'd0);
        chk("basic_latency", 64'(edges), 64'd34);
        chk("basic_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("basic_busy_in_done", {63'd0, busy}, 64'd0);
        chk("basic_prod", {prod_hi, prod_lo}, 64'h0000_0000_0000_002A);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("prod_hold_idle", {prod_hi, prod_lo}, 64'h0000_0000_0000_002A);

        run_op("signed_mixed", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("unsigned_mixed", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
        run_op("umax_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op("smin_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run_op("smin_x1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        run_op("signed_zero", 32'd0, 32'hFFFF_FFF0, 1'b1, 64'd0);

        // start pulse at cycle 10 of a running 7x6 is ignored.
        @(negedge clk);
        launch(32'd7, 32'd6, 1'b0);
        wait_done(10, 1'b0, 32'd0);
        chk("ignore_latency", 64'(edges), 64'd34);
        chk("ignore_prod", {prod_hi, prod_lo}, 64'd42);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("ignore_no_second_done", 64'(done_cnt), 64'd0);

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        launch(32'd7, 32'd6, 1'b0);
        wait_done(-1, 1'b0, 32'd0);
        chk("b2b_first_prod", {prod_hi, prod_lo}, 64'd42);
        launch(32'd3, 32'd4, 1'b0);
        wait_done(-1, 1'b1, 32'd42);
        chk("b2b_busy_rises", {63'd0, first_busy}, 64'd1);
        chk("b2b_latency", 64'(edges), 64'd34);
        chk("b2b_hold_42", {63'd0, hold_bad}, 64'd0);
        chk("b2b_second_prod", {prod_hi, prod_lo}, 64'd12);

        // Asynchronous reset mid-RUN.
        run_op("pre_reset", 32'd7, 32'd6, 1'b0, 64'd42);
        @(negedge clk);
        launch(32'd7, 32'd6, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_async", {30'd0, busy, done, prod_hi, prod_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("reset_no_done", 64'(done_cnt), 64'd0);
        run_op("after_reset", 32'd7, 32'd6, 1'b0, 64'd42);

        // Randomized operands against the reference product.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(1, 0));
            if (i % 6 == 5) a = 32'h8000_0000;
            run_op("random", a, b, s, ref_mul(a, b, s));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier producing a full 2·N_BITS product from two N_BITS operands, signed or unsigned. It sits in the execute stage directly upstream of the ALU result-select mux. Its low and high product words are two of that mux's sources, and its busy flag stalls the pipeline while a multiply is in flight. One product bit is retired per clock, trading latency for area against a combinational array multiplier.

## Interface
Parameters:
- N_BITS, 32, operand width; product is 2·N_BITS wide. Must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE or DONE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- src0  input  N_BITS  multiplicand; sampled with start
- src1  input  N_BITS  multiplier; sampled with start
- busy  output  1  high while a multiply is in progress (RUN or FIX)
- done  output  1  one-cycle pulse: product valid
- prod_lo  output  N_BITS  product bits [N_BITS-1:0]
- prod_hi  output  N_BITS  product bits [2·N_BITS-1:N_BITS]

## Operation
- **States:** IDLE, RUN, FIX, DONE, held in a 2-bit state register.
- **IDLE or DONE, start=1 (accepting edge):**
  - Latch operand magnitudes: |src| when is_signed=1 and the operand is negative, else raw.
  - Latch neg_result = is_signed & (src0[N-1] ^ src1[N-1]).
  - Clear the 2·N_BITS accumulator. Load iteration counter = 0. Go to RUN.
- **RUN, each edge:**
  - If the current LSB of the multiplier shift register is 1, add the multiplicand to the upper half of the accumulator, N_BITS+1 bits wide with the carry kept.
  - Shift the accumulator and multiplier right by 1.
  - Increment the counter. After N_BITS edges in RUN, go to FIX.
- **FIX, one edge:** if neg_result, write the two's-complement negation of the 2·N_BITS accumulator into prod_hi:prod_lo, else write it unchanged. Go to DONE.
- **DONE:** done=1 for exactly this cycle.
  - start=1 here is accepted (back-to-back) and goes to RUN.
  - Otherwise go to IDLE.
- **start while busy:** ignored entirely. No restart, no operand re-sample.
- **Output hold:** prod_hi/prod_lo change only at the FIX edge. They hold the last product through IDLE, RUN and DONE of later operations until the next FIX.
- **Width rules:**
  - Magnitude of the most negative value (-2^(N-1)) is 2^(N-1) and fits the unsigned N_BITS magnitude register. No overflow path.
  - All arithmetic is modulo 2^(2·N_BITS).
  - An operand of 0 with is_signed=1 never yields -0 (negating 0 gives 0).
- **Reset (any time, including mid-RUN):**
  - State goes to IDLE; busy=0, done=0, prod_lo=0, prod_hi=0.
  - Counter, accumulator and operand registers are cleared.
  - The in-flight operation is abandoned with no done pulse.

## Timing
- Accepting edge = edge E.
- busy is high in the cycles after edges E .. E+N_BITS (RUN, then FIX), i.e. N_BITS+1 cycles.
- The FIX edge is E+N_BITS+1. done is high and the product is valid in the cycle after that edge.
- Latency from E to done: N_BITS+2 edges (34 for N_BITS=32). Throughput: one multiply per N_BITS+2 cycles with back-to-back start.
- busy=0 during DONE, so the pipeline may issue the next start in the done cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Unsigned basic:** is_signed=0, src0=7, src1=6 → done exactly 34 cycles after the start edge; prod_hi=0x00000000, prod_lo=0x0000002A; busy high for exactly 33 cycles.
- **Signed mixed sign:** is_signed=1, src0=0xFFFFFFFD (-3), src1=5 → prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFF1. Same operands with is_signed=0 → prod_hi=0x00000004, prod_lo=0xFFFFFFF1.
- **Extremes:**
  - Unsigned 0xFFFFFFFF×0xFFFFFFFF → prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
  - Signed 0x80000000×0x80000000 → prod_hi=0x40000000, prod_lo=0.
  - Signed 0x80000000×1 → prod_hi=0xFFFFFFFF, prod_lo=0x80000000.
- **start while busy:** pulse start with src0=9, src1=9 at cycle 10 of a 7×6 operation → a single done pulse at the original time, product 42, no second done.
- **Back-to-back:** assert start with 3×4 in the done cycle of 7×6 → first done shows 42; busy rises on the next cycle; second done 34 cycles later shows 12. prod_lo holds 42 throughout the second operation.
- **Reset mid-operation:** assert rst asynchronously at cycle 15 of RUN → busy, done, prod_hi and prod_lo go to 0 immediately; no done pulse follows. After release, a fresh 7×6 completes normally.
